// File: rtl/sram_responder.sv
// Dual-port word SRAM responder with byte-lane writes, 1-cycle reads and sticky out-of-range capture.
// Optional SRAM_TIMER_EN macro adds a free-running timer register on the data port at TIMER_ADDR.
module sram_responder #(
    parameter int          ADDR_W     = 16,
    parameter logic [31:0] BASE       = 32'hBFC0_0000,
    parameter logic [31:0] TIMER_ADDR = 32'hBFAF_E000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        err_clr,
    output logic        err,
    output logic [31:0] err_addr
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              inst_in_range;
    logic              data_in_range;
    logic              data_timer_hit;
    logic              inst_rd;
    logic              inst_wr;
    logic              data_rd;
    logic              data_wr;
    logic              inst_miss;
    logic              data_miss;
    logic [31:0]       timer_val;
    logic              unused_ok;

    assign inst_idx      = inst_sram_addr[ADDR_W+1:2];
    assign data_idx      = data_sram_addr[ADDR_W+1:2];
    assign inst_in_range = (inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign data_in_range = (data_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);

`ifdef SRAM_TIMER_EN
    logic [31:0] timer_q;

    assign data_timer_hit = data_sram_en && (data_sram_addr[31:2] == TIMER_ADDR[31:2]);
    assign timer_val      = timer_q;

    // A data-port write to the timer replaces that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (data_timer_hit && (data_sram_wen != 4'b0000)) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    timer_q[8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end
`else
    assign data_timer_hit = 1'b0;
    assign timer_val      = '0;
`endif

    assign unused_ok = ^{TIMER_ADDR, inst_sram_addr[1:0], data_sram_addr[1:0]};

    assign inst_rd   = inst_sram_en && (inst_sram_wen == 4'b0000);
    assign data_rd   = data_sram_en && (data_sram_wen == 4'b0000);
    assign inst_wr   = inst_sram_en && (inst_sram_wen != 4'b0000) && inst_in_range;
    assign data_wr   = data_sram_en && (data_sram_wen != 4'b0000) && data_in_range && !data_timer_hit;
    assign inst_miss = inst_sram_en && !inst_in_range;
    assign data_miss = data_sram_en && !data_in_range && !data_timer_hit;

    // Data lane assignment follows the inst lane so the data port wins on a same-word collision.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (inst_wr && inst_sram_wen[b]) begin
                mem[inst_idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
            end
            if (data_wr && data_sram_wen[b]) begin
                mem[data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else begin
            if (inst_rd) begin
                inst_sram_rdata <= inst_in_range ? mem[inst_idx] : '0;
            end
            if (data_rd) begin
                data_sram_rdata <= data_timer_hit ? timer_val :
                                   data_in_range  ? mem[data_idx] : '0;
            end
        end
    end

    // A miss alongside err_clr counts as the first miss after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (inst_miss || data_miss) begin
            err <= 1'b1;
            if (!err || err_clr) begin
                err_addr <= data_miss ? data_sram_addr : inst_sram_addr;
            end
        end else if (err_clr) begin
            err      <= 1'b0;
            err_addr <= '0;
        end
    end
endmodule
